stopwatch_core: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 26 ++
 rtl/stopwatch_if.sv | 32 +++
 rtl/bcd_digit_counter.sv | 40 ++++
 rtl/stopwatch_core.sv | 117 +++++++++++
 tb/tb_stopwatch_core.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping slice.
//   sw_state_e : control FSM states
//   bcd_t      : one BCD digit
//   BcdMax9/5  : digit roll-over limits
//   tick_div() : system clocks per 1/100 s tick
package stopwatch_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRun   = 2'd1,
    StPause = 2'd2,
    StLap   = 2'd3
  } sw_state_e;

  typedef logic [3:0] bcd_t;

  localparam bcd_t BcdMax9 = 4'd9;
  localparam bcd_t BcdMax5 = 4'd5;

  localparam int unsigned NumDigits = 6;

  function automatic int unsigned tick_div(input int unsigned clk_hz);
    return clk_hz / 100;
  endfunction

endpackage

// File: rtl/stopwatch_if.sv
// Control pulses and display/status outputs of the stopwatch core.
//   start_stop, lap, clear : single-cycle debounced pulses into the core
//   a..f                   : BCD digits cc(lo,hi) SS(lo,hi) MM(lo,hi)
//   running, lap_active    : state decode
//   overflow               : one-cycle pulse on 59:59.99 -> 00:00.00
interface stopwatch_if;
  import stopwatch_pkg::*;

  logic start_stop;
  logic lap;
  logic clear;
  bcd_t a;
  bcd_t b;
  bcd_t c;
  bcd_t d;
  bcd_t e;
  bcd_t f;
  logic running;
  logic lap_active;
  logic overflow;

  modport master (
    output start_stop, lap, clear,
    input  a, b, c, d, e, f, running, lap_active, overflow
  );

  modport slave (
    input  start_stop, lap, clear,
    output a, b, c, d, e, f, running, lap_active, overflow
  );

endinterface

// File: rtl/bcd_digit_counter.sv
// One BCD digit that counts 0..MAX and wraps, with a ripple carry.
//   clk, rst_n : clock, synchronous active-low reset
//   clr        : synchronous zero (beats inc)
//   inc        : advance one step
//   q          : current digit
//   carry      : inc while at MAX (digit wraps this edge)
module bcd_digit_counter
  import stopwatch_pkg::*;
#(
  parameter bcd_t MAX = BcdMax9
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output bcd_t q,
  output logic carry
);

  bcd_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      // >= keeps the digit in range even from a corrupted value
      cnt_d = (cnt_q >= MAX) ? '0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign q     = cnt_q;
  assign carry = inc && (cnt_q == MAX);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch timekeeping engine: 1/100 s prescaler, MM:SS.cc BCD chain,
// start/stop/lap/clear FSM and live/lap display mux.
//   clk, rst_n : system clock, synchronous active-low reset
//   sw         : stopwatch_if slave (pulses in, digits and status out)
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  stopwatch_if.slave  sw
);

  localparam int unsigned Div = tick_div(CLK_HZ);
  localparam int unsigned PsW = (Div > 1) ? $clog2(Div) : 1;
  localparam logic [PsW-1:0] PsLast = PsW'(Div - 1);

  sw_state_e state_q, state_d;
  logic [PsW-1:0] presc_q, presc_d;
  bcd_t [NumDigits-1:0] live;
  bcd_t [NumDigits-1:0] lap_q, lap_d;
  bcd_t [NumDigits-1:0] disp;
  logic [NumDigits-1:0] carry;
  logic [NumDigits-1:0] inc;
  logic overflow_q, overflow_d;
  logic counting, tick, go_idle, take_lap;

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  // FSM: next state; start_stop beats lap beats clear
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (sw.start_stop) state_d = StRun;
      StRun: begin
        if (sw.start_stop)  state_d = StPause;
        else if (sw.lap)    state_d = StLap;
      end
      StLap: begin
        if (sw.start_stop)  state_d = StPause;
        else if (sw.lap)    state_d = StRun;
      end
      StPause: begin
        if (sw.start_stop)  state_d = StRun;
        else if (sw.clear)  state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Datapath control, decoded from the current state so a tick and a
  // start_stop on the same edge both take effect.
  always_comb begin
    counting = (state_q == StRun) || (state_q == StLap);
    tick     = counting && (presc_q == PsLast);
    go_idle  = (state_q == StPause) && (state_d == StIdle);
    take_lap = (state_q == StRun) && (state_d == StLap);

    presc_d = presc_q;
    if (go_idle)       presc_d = '0;
    else if (tick)     presc_d = '0;
    else if (counting) presc_d = presc_q + PsW'(1);

    // snapshot is the pre-increment value when a tick lands on the lap edge
    lap_d      = take_lap ? live : lap_q;
    overflow_d = carry[NumDigits-1];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q    <= '0;
      lap_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      lap_q      <= lap_d;
      overflow_q <= overflow_d;
    end
  end

  assign inc = {carry[NumDigits-2:0], tick};

  for (genvar i = 0; i < NumDigits; i++) begin : g_digit
    // digits 3 (seconds tens) and 5 (minutes tens) roll at 5
    localparam bcd_t Max = (i == 3 || i == 5) ? BcdMax5 : BcdMax9;
    bcd_digit_counter #(
      .MAX(Max)
    ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (go_idle),
      .inc   (inc[i]),
      .q     (live[i]),
      .carry (carry[i])
    );
  end

  // FSM: outputs
  always_comb begin
    disp          = (state_q == StLap) ? lap_q : live;
    sw.a          = disp[0];
    sw.b          = disp[1];
    sw.c          = disp[2];
    sw.d          = disp[3];
    sw.e          = disp[4];
    sw.f          = disp[5];
    sw.running    = (state_q == StRun) || (state_q == StLap);
    sw.lap_active = (state_q == StLap);
    sw.overflow   = overflow_q;
  end

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core at CLK_HZ=1000 (10 clocks per tick).
// Expectations are queued as stimulus is driven and popped at each sample.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  logic clk = 1'b0;
  logic rst_n;

  stopwatch_if bus ();

  stopwatch_core #(
    .CLK_HZ(1000)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .sw    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [23:0] val;
  } exp_t;

  exp_t sb_q[$];
  int checks = 0;
  int errors = 0;

  function automatic logic [23:0] digits();
    return {bus.f, bus.e, bus.d, bus.c, bus.b, bus.a};
  endfunction

  // {running, lap_active, overflow}
  function automatic logic [23:0] status();
    return {21'd0, bus.running, bus.lap_active, bus.overflow};
  endfunction

  task automatic expect_val(input string tag, input logic [23:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb_q.push_back(e);
  endtask

  task automatic check_val(input logic [23:0] obs);
    exp_t e;
    checks++;
    if (sb_q.size() == 0) begin
      errors++;
      $error("FAIL scoreboard_empty observed=%h expected=none", obs);
    end else begin
      e = sb_q.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed=%h expected=%h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // drive for exactly one rising edge
  task automatic pulse(input logic ss, input logic lp, input logic cl);
    bus.start_stop = ss;
    bus.lap        = lp;
    bus.clear      = cl;
    @(negedge clk);
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
    cyc(2);
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    do_reset();
    expect_val("reset_digits", 24'h000000);
    expect_val("reset_status", 24'h0);
    check_val(digits());
    check_val(status());

    // first tick DIV cycles after start, then 1000 cycles -> 00:01.00
    expect_val("start_running", 24'h4);
    pulse(1'b1, 1'b0, 1'b0);
    check_val(status());
    expect_val("pre_first_tick", 24'h000000);
    cyc(9);
    check_val(digits());
    expect_val("first_tick", 24'h000001);
    cyc(1);
    check_val(digits());
    expect_val("one_second", 24'h000100);
    cyc(990);
    check_val(digits());

    // wrap: pause, load 59:59.98, resume (prescaler held at 1)
    expect_val("pause_status", 24'h0);
    pulse(1'b1, 1'b0, 1'b0);
    check_val(status());
    force dut.g_digit[0].u_cnt.cnt_q = 4'd8;
    force dut.g_digit[1].u_cnt.cnt_q = 4'd9;
    force dut.g_digit[2].u_cnt.cnt_q = 4'd9;
    force dut.g_digit[3].u_cnt.cnt_q = 4'd5;
    force dut.g_digit[4].u_cnt.cnt_q = 4'd9;
    force dut.g_digit[5].u_cnt.cnt_q = 4'd5;
    cyc(1);
    release dut.g_digit[0].u_cnt.cnt_q;
    release dut.g_digit[1].u_cnt.cnt_q;
    release dut.g_digit[2].u_cnt.cnt_q;
    release dut.g_digit[3].u_cnt.cnt_q;
    release dut.g_digit[4].u_cnt.cnt_q;
    release dut.g_digit[5].u_cnt.cnt_q;
    expect_val("preload", 24'h595998);
    check_val(digits());
    pulse(1'b1, 1'b0, 1'b0);
    expect_val("max_time", 24'h595999);
    expect_val("max_status", 24'h4);
    cyc(9);
    check_val(digits());
    check_val(status());
    expect_val("wrap_digits", 24'h000000);
    expect_val("wrap_overflow", 24'h5);
    cyc(10);
    check_val(digits());
    check_val(status());
    expect_val("overflow_one_cycle", 24'h4);
    cyc(1);
    check_val(status());

    // lap freeze at 00:01.23
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    expect_val("lap_base", 24'h000123);
    cyc(1230);
    check_val(digits());
    expect_val("lap_status", 24'h6);
    expect_val("lap_frozen0", 24'h000123);
    pulse(1'b0, 1'b1, 1'b0);
    check_val(status());
    check_val(digits());
    expect_val("lap_frozen1", 24'h000123);
    cyc(25);
    check_val(digits());
    expect_val("unlap_live", 24'h000125);
    expect_val("unlap_status", 24'h4);
    pulse(1'b0, 1'b1, 1'b0);
    check_val(digits());
    check_val(status());

    // pause keeps sub-tick fraction
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    cyc(14);
    expect_val("frac_pause_digits", 24'h000001);
    expect_val("frac_pause_status", 24'h0);
    pulse(1'b1, 1'b0, 1'b0);
    check_val(digits());
    check_val(status());
    expect_val("pause_hold", 24'h000001);
    cyc(100);
    check_val(digits());
    pulse(1'b1, 1'b0, 1'b0);
    expect_val("resume_pre_tick", 24'h000001);
    cyc(4);
    check_val(digits());
    expect_val("resume_tick", 24'h000002);
    cyc(1);
    check_val(digits());

    // clear ignored in RUN, honoured in PAUSE
    expect_val("clear_run_status", 24'h4);
    expect_val("clear_run_digits", 24'h000002);
    pulse(1'b0, 1'b0, 1'b1);
    check_val(status());
    check_val(digits());
    pulse(1'b1, 1'b0, 1'b0);
    expect_val("clear_pause_digits", 24'h000000);
    expect_val("clear_pause_status", 24'h0);
    pulse(1'b0, 1'b0, 1'b1);
    check_val(digits());
    check_val(status());

    // start_stop beats clear in PAUSE, fraction retained
    pulse(1'b1, 1'b0, 1'b0);
    expect_val("restart_tick", 24'h000001);
    cyc(10);
    check_val(digits());
    pulse(1'b1, 1'b0, 1'b0);
    expect_val("ss_clear_status", 24'h4);
    expect_val("ss_clear_digits", 24'h000001);
    pulse(1'b1, 1'b0, 1'b1);
    check_val(status());
    check_val(digits());
    expect_val("ss_clear_pre_tick", 24'h000001);
    cyc(8);
    check_val(digits());
    expect_val("ss_clear_tick", 24'h000002);
    cyc(1);
    check_val(digits());

    // start_stop beats lap in RUN
    expect_val("ss_lap_status", 24'h0);
    pulse(1'b1, 1'b1, 1'b0);
    check_val(status());
    expect_val("lap_clear_pause_digits", 24'h000000);
    expect_val("lap_clear_pause_status", 24'h0);
    pulse(1'b0, 1'b1, 1'b1);
    check_val(digits());
    check_val(status());

    // reset during LAP at 00:10.00, with all pulses asserted
    do_reset();
    pulse(1'b1, 1'b0, 1'b0);
    expect_val("ten_seconds", 24'h001000);
    cyc(10000);
    check_val(digits());
    expect_val("lap10_status", 24'h6);
    pulse(1'b0, 1'b1, 1'b0);
    check_val(status());
    rst_n          = 1'b0;
    bus.start_stop = 1'b1;
    bus.lap        = 1'b1;
    bus.clear      = 1'b1;
    @(negedge clk);
    rst_n          = 1'b1;
    bus.start_stop = 1'b0;
    bus.lap        = 1'b0;
    bus.clear      = 1'b0;
    expect_val("lap_reset_digits", 24'h000000);
    expect_val("lap_reset_status", 24'h0);
    check_val(digits());
    check_val(status());
    expect_val("post_reset_digits", 24'h000000);
    expect_val("post_reset_status", 24'h0);
    cyc(20);
    check_val(digits());
    check_val(status());

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
